seq_stream_ctrl: RTL

Sequencing controller for the 8-state serial "go" pattern detector in the lab FSM set. It accepts words over a valid/ready stream and serializes them MSB-first onto the detector's go input, one bit per clk. It samples the detector's Mealy op output on every bit and reports a saturating match count per job. It owns the detector's reset so every job starts from detector state A.

---
 rtl/seq_stream_pkg.sv | 15 +
 rtl/seq_hold_reg.sv | 54 +++++
 rtl/seq_stream_ctrl.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/seq_stream_pkg.sv
// rtl/seq_stream_pkg.sv - shared state encoding and default widths for the go-pattern sequencer
package seq_stream_pkg;

  localparam int DEF_WORD_W = 8;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FIRST = 3'd1,
    SHIFT = 3'd2,
    STALL = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

endpackage

// File: rtl/seq_hold_reg.sv
// rtl/seq_hold_reg.sv - one-entry skid buffer holding the next word and its last flag
module seq_hold_reg #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              take,
  input  logic              flush,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              hold_valid,
  output logic [WORD_W-1:0] hold_data,
  output logic              hold_last
);

  logic              valid_q, valid_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              last_q, last_d;

  // A load wins over a take so a same-cycle transfer and refill keeps the entry full
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (take) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign hold_valid = valid_q;
  assign hold_data  = data_q;
  assign hold_last  = last_q;

endmodule

// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - serializes stream words MSB-first onto the detector go input and counts matches
module seq_stream_ctrl
  import seq_stream_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              det_reset,
  output logic              det_go,
  input  logic              det_op,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count,
  output logic              underrun
);

  localparam int BIT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  seq_state_e        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              last_q, last_d;
  logic              got_last_q, got_last_d;
  logic [CNT_W-1:0]  match_q, match_d;
  logic              underrun_q, underrun_d;

  logic              hold_valid;
  logic [WORD_W-1:0] hold_data;
  logic              hold_last;
  logic              hold_take;
  logic              hold_load;
  logic              feeding;
  logic              accept;

  // Outputs depend on registered state only, never directly on inputs
  assign feeding     = (state_q == SHIFT) || (state_q == STALL);
  assign in_ready    = (state_q == FIRST) || (feeding && !hold_valid && !got_last_q);
  assign det_reset   = (state_q == IDLE) || (state_q == FIRST) || (state_q == DONE);
  assign det_go      = (state_q == SHIFT) && shreg_q[WORD_W-1];
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign match_count = match_q;
  assign underrun    = underrun_q;

  assign accept    = in_valid && in_ready;
  assign hold_load = accept && feeding;

  seq_hold_reg #(
    .WORD_W(WORD_W)
  ) u_hold (
    .clk        (clk),
    .reset      (reset),
    .load       (hold_load),
    .take       (hold_take),
    .flush      (state_q == IDLE),
    .load_data  (in_data),
    .load_last  (in_last),
    .hold_valid (hold_valid),
    .hold_data  (hold_data),
    .hold_last  (hold_last)
  );

  // Next-state, shift/count datapath and skid-buffer hand-off
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    last_d     = last_q;
    got_last_d = got_last_q;
    match_d    = match_q;
    underrun_d = underrun_q;
    hold_take  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          match_d    = '0;
          underrun_d = 1'b0;
          got_last_d = 1'b0;
          state_d    = FIRST;
        end
      end
      FIRST: begin
        if (accept) begin
          shreg_d    = in_data;
          last_d     = in_last;
          got_last_d = in_last;
          bit_cnt_d  = '0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (det_op && (match_q != CNT_MAX)) begin
          match_d = match_q + CNT_W'(1);
        end
        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          if (last_q) begin
            state_d = DONE;
          end else if (hold_valid) begin
            shreg_d   = hold_data;
            last_d    = hold_last;
            bit_cnt_d = '0;
            hold_take = 1'b1;
          end else begin
            state_d = STALL;
          end
        end
      end
      STALL: begin
        // The detector sees a zero bit here, which can never complete a match
        underrun_d = 1'b1;
        if (hold_valid) begin
          shreg_d   = hold_data;
          last_d    = hold_last;
          bit_cnt_d = '0;
          hold_take = 1'b1;
          state_d   = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (hold_load && in_last) begin
      got_last_d = 1'b1;
    end
  end

  // Controller state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      last_q     <= 1'b0;
      got_last_q <= 1'b0;
      match_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      last_q     <= last_d;
      got_last_q <= got_last_d;
      match_q    <= match_d;
      underrun_q <= underrun_d;
    end
  end

endmodule
